// File: rtl/bus_rr_matrix.sv
// rtl/bus_rr_matrix.sv - shared single-channel bus between NUM_M masters and NUM_S slaves
// Registered round-robin arbiter with hold/tenure limit, region decode, registered read return.
module bus_rr_matrix #(
  parameter int NUM_M    = 2,
  parameter int NUM_S    = 2,
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int SLV_SIZE = 32,
  parameter int MAX_HOLD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0]    m_grant,
  output logic [DW-1:0]       m_din,
  output logic                m_err,
  output logic [NUM_S-1:0]    s_sel,
  output logic [AW-1:0]       s_addr,
  output logic                s_wr,
  output logic [DW-1:0]       s_din,
  input  logic [NUM_S*DW-1:0] s_dout
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int TW = $clog2(MAX_HOLD + 2);
  localparam int SH = $clog2(SLV_SIZE);
  localparam logic [TW-1:0] TMAX = TW'(MAX_HOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_n;
  logic [MW-1:0]    owner, owner_n, ptr, ptr_n, pick;
  logic [TW-1:0]    tenure, tenure_n, tenure_inc;
  logic [NUM_S-1:0] rd_sel;
  logic [AW-1:0]    slv_idx;
  logic             own_v, any_req, others;

  // First requester after p in circular order; p itself is checked last.
  function automatic logic [MW-1:0] rr_pick(input logic [NUM_M-1:0] req, input logic [MW-1:0] p);
    logic [MW-1:0] r;
    r = p;
    for (int n = NUM_M; n >= 1; n--) begin
      if (req[(int'(p) + n) % NUM_M]) r = MW'((int'(p) + n) % NUM_M);
    end
    return r;
  endfunction

  assign own_v      = (state == OWN);
  assign any_req    = |m_req;
  assign others     = |(m_req & ~m_grant);
  assign pick       = rr_pick(m_req, ptr);
  assign tenure_inc = (tenure == TMAX) ? tenure : tenure + 1'b1;
  assign slv_idx    = s_addr >> SH;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      ptr    <= MW'(NUM_M - 1);
      tenure <= '0;
      rd_sel <= '0;
      m_err  <= 1'b0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      ptr    <= ptr_n;
      tenure <= tenure_n;
      rd_sel <= s_sel;
      m_err  <= own_v & ~(|s_sel);
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    ptr_n    = ptr;
    tenure_n = tenure;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n  = OWN;
          owner_n  = pick;
          ptr_n    = pick;
          tenure_n = '0;
        end
      end
      OWN: begin
        if (!m_req[owner]) begin
          tenure_n = '0;
          if (any_req) begin
            owner_n = pick;
            ptr_n   = pick;
          end else begin
            state_n = IDLE;
          end
        end else if ((MAX_HOLD > 0) && (tenure_inc >= TMAX) && others) begin
          // Tenure exhausted with competition: hand over without an idle cycle.
          owner_n  = pick;
          ptr_n    = pick;
          tenure_n = '0;
        end else begin
          tenure_n = tenure_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    m_grant = '0;
    s_sel   = '0;
    s_addr  = '0;
    s_wr    = 1'b0;
    s_din   = '0;
    if (own_v) begin
      s_addr = m_addr[int'(owner)*AW +: AW];
      s_wr   = m_wr[owner];
      s_din  = m_dout[int'(owner)*DW +: DW];
    end
    for (int i = 0; i < NUM_M; i++) m_grant[i] = own_v && (owner == MW'(i));
    // Addresses beyond the last region select nothing, so unmapped writes are dropped.
    for (int k = 0; k < NUM_S; k++) s_sel[k] = own_v && (slv_idx == AW'(k));
  end

  always_comb begin
    m_din = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (rd_sel[k]) m_din = m_din | s_dout[k*DW +: DW];
    end
  end

endmodule

// File: tb/tb_bus_rr_matrix.sv
// tb/tb_bus_rr_matrix.sv - scoreboard bench for bus_rr_matrix against a cycle-level reference model
module tb_bus_rr_matrix;

  localparam int NUM_M    = 3;
  localparam int NUM_S    = 2;
  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int SLV_SIZE = 32;
  localparam int MAX_HOLD = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_M-1:0]    m_req, m_wr, m_grant;
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_dout;
  logic [DW-1:0]       m_din;
  logic                m_err;
  logic [NUM_S-1:0]    s_sel;
  logic [AW-1:0]       s_addr;
  logic                s_wr;
  logic [DW-1:0]       s_din;
  logic [NUM_S*DW-1:0] s_dout;

  bus_rr_matrix #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SLV_SIZE(SLV_SIZE), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din), .m_err(m_err), .s_sel(s_sel), .s_addr(s_addr),
    .s_wr(s_wr), .s_din(s_din), .s_dout(s_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_M-1:0] grant;
    logic [NUM_S-1:0] sel;
    logic [AW-1:0]    addr;
    logic             wr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference state: owner/rd_slv use -1 for "none"; held counts completed owned cycles.
  int   owner, ptr, held, rd_slv;
  logic err_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int cur_addr();
    return (owner >= 0) ? int'(m_addr[owner*AW +: AW]) : 0;
  endfunction

  task automatic issue();
    exp_t e;
    int   a, slv;
    a       = cur_addr();
    slv     = a / SLV_SIZE;
    e.grant = (owner >= 0) ? (NUM_M'(1) << owner) : '0;
    e.addr  = AW'(a);
    e.wr    = (owner >= 0) ? m_wr[owner] : 1'b0;
    e.wdata = (owner >= 0) ? m_dout[owner*DW +: DW] : '0;
    e.sel   = (owner >= 0 && slv < NUM_S) ? (NUM_S'(1) << slv) : '0;
    e.rdata = (rd_slv >= 0) ? s_dout[rd_slv*DW +: DW] : '0;
    e.err   = err_r;
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    int slv, nxt;
    if (reset) begin
      owner = -1; ptr = NUM_M - 1; held = 0; rd_slv = -1; err_r = 1'b0;
      return;
    end
    slv    = cur_addr() / SLV_SIZE;
    rd_slv = (owner >= 0 && slv < NUM_S) ? slv : -1;
    err_r  = (owner >= 0 && slv >= NUM_S);
    nxt = -1;
    for (int k = 1; k <= NUM_M; k++) begin
      if (nxt < 0 && m_req[(ptr + k) % NUM_M]) nxt = (ptr + k) % NUM_M;
    end
    if (owner < 0) begin
      if (nxt >= 0) begin owner = nxt; ptr = nxt; held = 0; end
    end else if (!m_req[owner]) begin
      held = 0;
      if (nxt >= 0) begin owner = nxt; ptr = nxt; end
      else owner = -1;
    end else begin
      held++;
      if (MAX_HOLD > 0 && held >= MAX_HOLD && nxt != owner) begin
        owner = nxt; ptr = nxt; held = 0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [NUM_M-1:0] req, input logic [NUM_M-1:0] wr,
                      input logic [NUM_M*AW-1:0] addr, input logic fixed_data);
    reset  = rst;
    m_req  = req;
    m_wr   = wr;
    m_addr = addr;
    for (int i = 0; i < NUM_M; i++) m_dout[i*DW +: DW] = fixed_data ? 32'h12345678 : $urandom;
    if (fixed_data) s_dout = {32'hBEEF0002, 32'hCAFE0001};
    else for (int k = 0; k < NUM_S; k++) s_dout[k*DW +: DW] = $urandom;
    issue();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("m_grant", 64'(m_grant), 64'(e.grant));
      chk("s_sel",   64'(s_sel),   64'(e.sel));
      chk("s_addr",  64'(s_addr),  64'(e.addr));
      chk("s_wr",    64'(s_wr),    64'(e.wr));
      chk("s_din",   64'(s_din),   64'(e.wdata));
      chk("m_din",   64'(m_din),   64'(e.rdata));
      chk("m_err",   64'(m_err),   64'(e.err));
    end
  end

  initial begin
    logic [NUM_M-1:0]    req, wr;
    logic [NUM_M*AW-1:0] addr;
    reset  = 1'b1;
    m_req  = '0;
    m_wr   = '0;
    m_addr = '0;
    m_dout = '0;
    s_dout = '0;
    @(posedge clk);
    model_edge();
    #1;
    step(1'b1, 3'b000, 3'b000, {8'h00, 8'h00, 8'h10}, 1'b1);
    // Single master read of slave 0, then write to slave 1, then unmapped access.
    repeat (3) step(1'b0, 3'b001, 3'b000, {8'h00, 8'h00, 8'h10}, 1'b1);
    step(1'b0, 3'b001, 3'b001, {8'h00, 8'h00, 8'h25}, 1'b1);
    step(1'b0, 3'b001, 3'b000, {8'h00, 8'h00, 8'h40}, 1'b1);
    step(1'b0, 3'b001, 3'b000, {8'h00, 8'h00, 8'h3C}, 1'b1);
    step(1'b0, 3'b000, 3'b000, {8'h00, 8'h00, 8'h3C}, 1'b1);
    step(1'b0, 3'b000, 3'b000, {8'h00, 8'h00, 8'h3C}, 1'b1);
    // Handover without idle, re-raise and drop.
    step(1'b1, 3'b011, 3'b000, {8'h00, 8'h30, 8'h08}, 1'b1);
    step(1'b0, 3'b011, 3'b000, {8'h00, 8'h30, 8'h08}, 1'b1);
    step(1'b0, 3'b011, 3'b000, {8'h00, 8'h30, 8'h08}, 1'b1);
    step(1'b0, 3'b010, 3'b000, {8'h00, 8'h30, 8'h08}, 1'b1);
    step(1'b0, 3'b001, 3'b000, {8'h00, 8'h30, 8'h08}, 1'b1);
    step(1'b0, 3'b001, 3'b000, {8'h00, 8'h30, 8'h08}, 1'b1);
    // All masters held: tenure-limited rotation.
    repeat (14) step(1'b0, 3'b111, 3'b000, {8'h44, 8'h30, 8'h08}, 1'b1);
    // Reset in the middle of an owned read.
    step(1'b1, 3'b111, 3'b000, {8'h44, 8'h30, 8'h08}, 1'b1);
    repeat (3) step(1'b0, 3'b111, 3'b000, {8'h44, 8'h30, 8'h08}, 1'b1);
    req = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_M; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 95));
      end
      wr = NUM_M'($urandom);
      step(($urandom_range(0, 99) == 0), req, wr, addr, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
